// File: rtl/nes_pad_responder.sv
// NES controller emulator: answers the console's latch/clock protocol with the
// active-low serial button stream, from a 50 MHz system clock.
module nes_pad_responder #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk50,
  input  logic       i_rst,
  input  logic [7:0] i_buttons,
  input  logic       i_pad_latch,
  input  logic       i_pad_clk,
  output logic       o_pad_data,
  output logic       o_frame_done,
  output logic       o_active
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  logic [SYNC_STAGES-1:0] latch_sync_q, clk_sync_q;
  logic                   clk_prev_q;
  logic                   latch_s, clk_s, shift_ev;

  state_e          state_q, state_d;
  logic [7:0]      sr_q, sr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            pad_q, pad_d;
  logic            done_q, done_d;

  // Synchronizers reset to the pins' idle levels so release causes no false edge.
  always_ff @(posedge i_clk50) begin
    if (i_rst) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '1;
      clk_prev_q   <= 1'b1;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], i_pad_latch};
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], i_pad_clk};
      clk_prev_q   <= clk_s;
    end
  end

  assign latch_s  = latch_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign shift_ev = clk_s & ~clk_prev_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    // Latch has priority in every state, so a coincident shift is dropped.
    if (latch_s) begin
      state_d = StLoad;
      sr_d    = ~i_buttons;
      cnt_d   = 4'd0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        StIdle: ;
        StLoad: begin
          state_d = StShift;
          tmo_d   = '0;
        end
        StShift: begin
          if (shift_ev) begin
            sr_d  = {1'b0, sr_q[7:1]};
            cnt_d = cnt_q + 4'd1;
            tmo_d = '0;
            if (cnt_q == 4'd7) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end else if (tmo_q == TmoLast) begin
            state_d = StIdle;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output bit is registered from the updated shift register, adding one cycle.
  always_comb begin
    pad_d = 1'b1;
    case (state_q)
      StIdle:  pad_d = 1'b1;
      StLoad:  pad_d = sr_q[0];
      StShift: pad_d = sr_q[0];
      StDone:  pad_d = 1'b0;
      default: pad_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk50) begin
    if (i_rst) begin
      state_q <= StIdle;
      sr_q    <= 8'hFF;
      cnt_q   <= 4'd0;
      tmo_q   <= '0;
      pad_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      pad_q   <= pad_d;
      done_q  <= done_d;
    end
  end

  assign o_pad_data   = pad_q;
  assign o_frame_done = done_q;
  assign o_active     = (state_q == StLoad) || (state_q == StShift);

endmodule

// File: tb/tb_nes_pad_responder.sv
// Directed bench for nes_pad_responder: full frames, overrun, abort, timeout,
// reset mid-frame and coincident latch/clock edges.
module tb_nes_pad_responder;

  logic       clk;
  logic       rst;
  logic [7:0] buttons;
  logic       pad_latch;
  logic       pad_clk;
  logic       pad_data;
  logic       frame_done;
  logic       active;

  int checks = 0;
  int errors = 0;
  int fd_cycles = 0;
  int fd_bad = 0;
  logic prev_active = 1'b0;
  logic [7:0] exp_bits;

  nes_pad_responder #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(50000)
  ) dut (
    .i_clk50     (clk),
    .i_rst       (rst),
    .i_buttons   (buttons),
    .i_pad_latch (pad_latch),
    .i_pad_clk   (pad_clk),
    .o_pad_data  (pad_data),
    .o_frame_done(frame_done),
    .o_active    (active)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Frame-done pulses must be one cycle wide and coincide with o_active falling.
  always @(negedge clk) begin
    if (frame_done) begin
      fd_cycles++;
      if (active || !prev_active) fd_bad++;
    end
    prev_active = active;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 12 us latch at 50 MHz, then a short settle before the first bit is read.
  task automatic latch_pulse();
    pad_latch = 1'b1;
    repeat (600) @(negedge clk);
    pad_latch = 1'b0;
    repeat (60) @(negedge clk);
  endtask

  // One 6 us console clock period: low half, then rising edge and high half.
  task automatic shift_pulse();
    pad_clk = 1'b0;
    repeat (150) @(negedge clk);
    pad_clk = 1'b1;
    repeat (150) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    buttons   = 8'h00;
    pad_latch = 1'b0;
    pad_clk   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pad", pad_data, 1);
    check("rst_active", active, 0);
    check("rst_done", frame_done, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // A+Start: ~8'h09 = 8'b1111_0110 -> bits 0,1,1,0,1,1,1,1
    buttons  = 8'h09;
    exp_bits = 8'b1111_0110;
    latch_pulse();
    check("f1_active", active, 1);
    check("f1_bit0", pad_data, exp_bits[0]);
    // First shift doubles as the fixed-latency check (SYNC_STAGES+2 = 4 cycles).
    pad_clk = 1'b0;
    repeat (150) @(negedge clk);
    pad_clk = 1'b1;
    repeat (3) @(negedge clk);
    check("lat_hold", pad_data, exp_bits[0]);
    @(negedge clk);
    check("lat_change", pad_data, exp_bits[1]);
    repeat (146) @(negedge clk);
    for (int k = 2; k < 8; k++) begin
      shift_pulse();
      check($sformatf("f1_bit%0d", k), pad_data, exp_bits[k]);
    end
    check("f1_active_before_8th", active, 1);
    check("f1_no_done_yet", fd_cycles, 0);
    shift_pulse();
    check("f1_done_count", fd_cycles, 1);
    check("f1_active_after", active, 0);
    check("f1_fill", pad_data, 0);

    // Overrun: four extra clocks give fill zeros and no second done.
    for (int k = 0; k < 4; k++) begin
      shift_pulse();
      check($sformatf("extra%0d", k), pad_data, 0);
    end
    check("extra_done_count", fd_cycles, 1);

    // Abort after 3 shifts with new buttons 8'h5A: ~ = 8'b1010_0101
    latch_pulse();
    for (int k = 1; k <= 3; k++) shift_pulse();
    check("ab_bit3", pad_data, exp_bits[3]);
    buttons  = 8'h5A;
    exp_bits = 8'b1010_0101;
    latch_pulse();
    check("ab_reload", pad_data, exp_bits[0]);
    check("ab_active", active, 1);
    check("ab_no_done", fd_cycles, 1);
    for (int k = 1; k < 8; k++) begin
      shift_pulse();
      check($sformatf("ab_bit%0d", k), pad_data, exp_bits[k]);
    end
    shift_pulse();
    check("ab_done_count", fd_cycles, 2);
    check("ab_fill", pad_data, 0);

    // Timeout: stop after 5 shifts; still active just before 50000 cycles, idle after.
    buttons = 8'h09;
    latch_pulse();
    for (int k = 1; k <= 5; k++) shift_pulse();
    check("to_active_pre", active, 1);
    repeat (49800) @(negedge clk);
    check("to_active_boundary", active, 1);
    repeat (100) @(negedge clk);
    check("to_active", active, 0);
    check("to_pad", pad_data, 1);
    check("to_no_done", fd_cycles, 2);

    // Reset after 4 shifts of an all-pressed frame.
    buttons = 8'hFF;
    latch_pulse();
    check("rs_bit0", pad_data, 0);
    for (int k = 1; k <= 4; k++) shift_pulse();
    check("rs_bit4", pad_data, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rs_pad", pad_data, 1);
    check("rs_active", active, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    latch_pulse();
    check("rs2_bit0", pad_data, 0);
    for (int k = 1; k < 8; k++) begin
      shift_pulse();
      check($sformatf("rs2_bit%0d", k), pad_data, 0);
    end
    shift_pulse();
    check("rs2_done_count", fd_cycles, 3);

    // Latch and clock rise together mid-frame: latch wins, counter restarts.
    // B only: ~8'h02 = 8'b1111_1101
    buttons = 8'h02;
    latch_pulse();
    for (int k = 1; k <= 2; k++) shift_pulse();
    pad_clk = 1'b0;
    repeat (150) @(negedge clk);
    pad_clk   = 1'b1;
    pad_latch = 1'b1;
    repeat (600) @(negedge clk);
    check("sim_bit0_latched", pad_data, 1);
    pad_latch = 1'b0;
    repeat (60) @(negedge clk);
    check("sim_bit0", pad_data, 1);
    check("sim_active", active, 1);
    shift_pulse();
    check("sim_bit1", pad_data, 0);
    for (int k = 2; k < 8; k++) begin
      shift_pulse();
      check($sformatf("sim_bit%0d", k), pad_data, 1);
    end
    check("sim_no_early_done", fd_cycles, 3);
    shift_pulse();
    check("sim_done_count", fd_cycles, 4);
    check("sim_fill", pad_data, 0);

    check("done_pulse_shape", fd_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nes_pad_responder.md
NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops in each input synchronizer (legal range 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, idle clock-cycles (1 ms at 50 MHz) after which a partial frame is abandoned.
REQ-003 SHALL have port i_clk50  input  1  sole clock, 50 MHz; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_buttons  input  8  pressed=1, already in i_clk50 domain; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
REQ-006 SHALL have port i_pad_latch  input  1  console latch strobe, asynchronous, active-high.
REQ-007 SHALL have port i_pad_clk  input  1  console shift clock, asynchronous, idles high; a shift is its rising edge.
REQ-008 SHALL have port o_pad_data  output  1  serial data to console, active-low (0 = pressed).
REQ-009 SHALL have port o_frame_done  output  1  one-cycle pulse when the 8th bit has been shifted out.
REQ-010 SHALL have port o_active  output  1  high while a frame is loaded or shifting.

Function
REQ-011 SHALL pass i_pad_latch and i_pad_clk through SYNC_STAGES-flop synchronizers; all decisions use synchronized values only.
REQ-012 SHALL detect a shift event as synchronized clock 0 in the previous cycle and 1 in the current cycle.
REQ-013 SHALL implement states IDLE, LOAD, SHIFT, DONE, held in registers.
REQ-014 IDLE: o_pad_data=1, o_active=0; synchronized latch high -> LOAD.
REQ-015 LOAD: every cycle with synchronized latch high, shift register <= ~i_buttons and bit counter <= 0; o_pad_data = ~i_buttons[0] as registered; latch falling -> SHIFT with the last loaded value frozen.
REQ-016 SHIFT: on each shift event, shift register moves right by one, filling 0 at bit7, counter increments; o_pad_data = shift register bit0, registered, updated the cycle after the event.
REQ-017 SHIFT: shift event that makes counter 8 -> DONE and o_frame_done=1 for exactly that one cycle.
REQ-018 DONE: o_pad_data=0 (fill bits) for any further shift events; o_active=0; synchronized latch high -> LOAD.
REQ-019 Latch high in SHIFT or DONE SHALL abort and go to LOAD; no o_frame_done for an aborted frame.
REQ-020 Latch high and shift event in the same cycle: latch wins, load performed, no shift, counter stays 0.
REQ-021 Shift events in IDLE or LOAD SHALL be ignored.
REQ-022 Timeout counter SHALL clear on every shift event and on entering SHIFT; reaching TIMEOUT_CYCLES in SHIFT -> IDLE without o_frame_done.
REQ-023 o_active SHALL be 1 in LOAD and SHIFT, 0 otherwise.
REQ-024 Latency pin edge -> o_pad_data change SHALL be SYNC_STAGES+2 cycles, fixed.
REQ-025 Counter SHALL be 4 bits and never exceed 8; shift events beyond 8 leave counter at 8.

Reset
REQ-026 i_rst high at a rising edge SHALL force IDLE, shift register 0xFF, counter 0, timeout counter 0, synchronizer flops to latch 0 / clock 1, o_pad_data=1, o_frame_done=0, o_active=0.
REQ-027 Reset mid-frame SHALL discard the frame; first latch after release starts a fresh LOAD.
REQ-028 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-029 i_buttons=8'b0000_1001 (A+Start), latch pulse 12 us, 8 clock pulses 6 us period -> o_pad_data sequence 0,1,1,0,1,1,1,1, one o_frame_done pulse, o_active falls with it.
REQ-030 Same frame plus 4 extra clock pulses -> o_pad_data 0 for all four, no second o_frame_done.
REQ-031 Latch reasserted after 3 shifts -> reload observed, no o_frame_done, next 8 shifts give full new pattern.
REQ-032 Stop clocking after 5 shifts, wait 50000 cycles -> state IDLE, o_pad_data=1, o_active=0, no o_frame_done.
REQ-033 i_rst asserted after 4 shifts with i_buttons=0xFF -> next cycle o_pad_data=1, o_active=0; following frame yields eight 0 bits.
REQ-034 Latch and clock rising edges driven simultaneously -> counter stays 0, o_pad_data = ~i_buttons[0].
